pipeline_ctrl: RTL

Hazard and sequencing controller for the five-stage MIPS pipeline. Sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable, hold and flush controls. It handles load-use stalls, taken-branch/jump redirects, multi-cycle EX operations and the syscall-exit halt sequence. It owns the `halt_ex` input of the ID/EX register, which forces syscall code 10 into EX.

---
 rtl/pipeline_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the five-stage MIPS pipeline.
// Drives PC / IF/ID / ID/EX enables, flushes and holds for load-use stalls,
// taken-branch/jump redirects, multi-cycle mult/div operations and the
// exit-syscall drain-and-halt sequence. Owns the halt_ex input of ID/EX.
//
// Optional build macro: PIPE_CTRL_STATS_EN
//   defined     -> stall_cycles / flush_events statistics counters are built
//   not defined -> both statistics ports are tied to zero
//
// Parameter DRAIN_CYCLES: legal range 1..15.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        uses_rs_id,
    input  logic        uses_rt_id,
    input  logic        MemRead_id_ex,
    input  logic [4:0]  rt_id_ex,
    input  logic        branch_taken_ex,
    input  logic        jump_ex,
    input  logic        syscall_halt_id,
    input  logic        md_start_ex,
    input  logic        md_done,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        id_ex_hold,
    output logic        halt_ex,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    // Drain length loaded when the exit syscall is detected.
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] drain_cnt_r;
    logic [3:0] drain_cnt_next_s;

    logic       redirect_s;
    logic       load_use_s;

    logic       pc_write_s;
    logic       if_id_write_s;
    logic       if_id_flush_s;
    logic       id_ex_flush_s;
    logic       id_ex_hold_s;
    logic       halt_ex_s;
    logic       halted_s;

    // A redirect resolved in EX makes everything younger wrong-path.
    assign redirect_s = branch_taken_ex | jump_ex;

    // Load in EX whose destination (non-zero) is read by the ID instruction.
    assign load_use_s = MemRead_id_ex
                     && (rt_id_ex != 5'd0)
                     && ((uses_rs_id && (rs_id == rt_id_ex))
                      || (uses_rt_id && (rt_id == rt_id_ex)));

    // State and drain-counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
        end
    end

    // Next-state and control outputs; reset overrides to a flush-everything pattern.
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        pc_write_s       = 1'b0;
        if_id_write_s    = 1'b0;
        if_id_flush_s    = 1'b0;
        id_ex_flush_s    = 1'b0;
        id_ex_hold_s     = 1'b0;
        halt_ex_s        = 1'b0;
        halted_s         = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (redirect_s) begin
                    // Wrong-path ID: load-use and syscall in ID are ignored.
                    // IF/ID stays writable so the flush actually lands.
                    pc_write_s    = 1'b1;
                    if_id_write_s = 1'b1;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    if (md_start_ex) begin
                        state_next_s = ST_MD_WAIT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (md_start_ex) begin
                    // Freeze front end; ID contents are re-evaluated after the op.
                    id_ex_hold_s = 1'b1;
                    state_next_s = ST_MD_WAIT;
                end else if (load_use_s) begin
                    // One bubble; the load moves on so the condition clears itself.
                    id_ex_flush_s = 1'b1;
                end else if (syscall_halt_id) begin
                    // Syscall proceeds into EX as code 10; the fetch behind it dies.
                    halt_ex_s        = 1'b1;
                    if_id_write_s    = 1'b1;
                    if_id_flush_s    = 1'b1;
                    state_next_s     = ST_DRAIN;
                    drain_cnt_next_s = DRAIN_INIT;
                end else begin
                    pc_write_s    = 1'b1;
                    if_id_write_s = 1'b1;
                end
            end

            ST_MD_WAIT: begin
                id_ex_hold_s = 1'b1;
                if (md_done) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_MD_WAIT;
                end
            end

            ST_DRAIN: begin
                id_ex_flush_s = 1'b1;
                if (drain_cnt_r <= 4'd1) begin
                    state_next_s     = ST_HALTED;
                    drain_cnt_next_s = 4'd0;
                end else begin
                    state_next_s     = ST_DRAIN;
                    drain_cnt_next_s = drain_cnt_r - 4'd1;
                end
            end

            ST_HALTED: begin
                halted_s      = 1'b1;
                id_ex_flush_s = 1'b1;
            end

            default: begin
                state_next_s     = ST_RUN;
                drain_cnt_next_s = 4'd0;
            end
        endcase

        if (rst) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            id_ex_hold_s  = 1'b0;
            halt_ex_s     = 1'b0;
            halted_s      = 1'b0;
        end else begin
            halted_s = halted_s;
        end
    end

    assign pc_write    = pc_write_s;
    assign if_id_write = if_id_write_s;
    assign if_id_flush = if_id_flush_s;
    assign id_ex_flush = id_ex_flush_s;
    assign id_ex_hold  = id_ex_hold_s;
    assign halt_ex     = halt_ex_s;
    assign halted      = halted_s;

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_events_r;
    logic        stats_live_s;

    // Counters only advance while the pipeline is live (RUN or MD_WAIT).
    assign stats_live_s = (state_r == ST_RUN) || (state_r == ST_MD_WAIT);

    // Statistics counters: stalled cycles and cycles carrying any flush in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
            flush_events_r <= 32'd0;
        end else begin
            if (stats_live_s && !pc_write_s) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if ((state_r == ST_RUN) && (if_id_flush_s || id_ex_flush_s)) begin
                flush_events_r <= flush_events_r + 32'd1;
            end else begin
                flush_events_r <= flush_events_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_events = flush_events_r;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule
